// File: rtl/spi_miso_tx_if.sv
// spi_miso_tx_if: bundle of the SPI pins and the word-side handshake of spi_miso_tx.
// The slave modport is the framing engine's view; master is the view of whoever
// drives the SPI pins and feeds or consumes words (the ARM model plus the FPGA logic).
interface spi_miso_tx_if #(
   parameter int WIDTH = 16
);
   logic             spck;
   logic             ncs;
   logic             mosi;
   logic             miso;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             underrun;
   logic             frame_err;
   logic             busy;

   modport slave (
      input  spck, ncs, mosi, tx_data, tx_valid,
      output miso, tx_ready, rx_data, rx_valid, underrun, frame_err, busy
   );

   modport master (
      output spck, ncs, mosi, tx_data, tx_valid,
      input  miso, tx_ready, rx_data, rx_valid, underrun, frame_err, busy
   );
endinterface

// File: rtl/spi_miso_tx.sv
// spi_miso_tx: SPI mode-0 slave framing engine, oversampled in the pck0 domain.
// Shifts a WIDTH-bit word out on miso (MSB first) while collecting the word the
// master clocks in on mosi. A one-entry holding register decouples the word source.
// Optional feature macro: SPI_TX_RETRY_EN -- keep the held word until a frame of
// exactly WIDTH bits completes, so an aborted frame resends the same word.
module spi_miso_tx #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] IDLE_WORD   = '0,
   parameter int               SYNC_STAGES = 2
) (
   input  logic          pck0,
   input  logic          rst,
   spi_miso_tx_if.slave  bus
);

   localparam int              CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      OVER  = 2'd2
   } state_t;

   // synchroniser chains and the one-cycle-delayed copy used for edge detection
   logic [SYNC_STAGES-1:0] spck_sync;
   logic [SYNC_STAGES-1:0] ncs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   spck_d;
   logic                   ncs_d;

   logic spck_s;
   logic ncs_s;
   logic mosi_s;
   logic spck_rise;
   logic spck_fall;
   logic ncs_fall;
   logic ncs_rise;

   // framing state
   state_t           state;
   logic [CNT_W-1:0] bit_cnt;
   logic             extra;      // an spck rise arrived after the last bit
   logic [WIDTH-1:0] shift;
   logic [WIDTH-1:0] rx_shift;
   logic [WIDTH-1:0] rx_next;
   logic [WIDTH-1:0] hold;
   logic             full;
`ifdef SPI_TX_RETRY_EN
   logic             loaded;     // held word went out in the current frame
`endif

   // registered outputs
   logic             miso_q;
   logic [WIDTH-1:0] rx_data_q;
   logic             rx_valid_q;
   logic             underrun_q;
   logic             frame_err_q;
   logic             busy_q;

   logic             tx_ready;
   logic             accept;

   // Synchronise the asynchronous SPI pins into pck0 and keep one extra stage for edges.
   // NOTE: ncs resets to 0 (asserted) so a reset taken mid-frame cannot fake a fresh
   // falling edge; the rising edge that follows is ignored because the FSM is IDLE.
   always_ff @(posedge pck0 or posedge rst) begin
      if (rst) begin
         spck_sync <= '0;
         ncs_sync  <= '0;
         mosi_sync <= '0;
         spck_d    <= 1'b0;
         ncs_d     <= 1'b0;
      end else begin
         spck_sync <= {spck_sync[SYNC_STAGES-2:0], bus.spck};
         ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0],  bus.ncs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
         spck_d    <= spck_sync[SYNC_STAGES-1];
         ncs_d     <= ncs_sync[SYNC_STAGES-1];
      end
   end

   assign spck_s    = spck_sync[SYNC_STAGES-1];
   assign ncs_s     = ncs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign spck_rise = spck_s & ~spck_d;
   assign spck_fall = ~spck_s & spck_d;
   assign ncs_fall  = ~ncs_s & ncs_d;
   assign ncs_rise  = ncs_s & ~ncs_d;

   assign rx_next = {rx_shift[WIDTH-2:0], mosi_s};

`ifdef SPI_TX_RETRY_EN
   // The held word stays owned by the engine for the whole frame.
   assign tx_ready = ~full & (state == IDLE);
`else
   assign tx_ready = ~full;
`endif
   assign accept = bus.tx_valid & tx_ready;

   // Framing FSM, holding register and all registered outputs; load and accept
   // share this block because they meet in the same cycle at frame start.
   // NOTE: every assignment here is non-blocking so all reads see the pre-edge values;
   // a later assignment to the same register in this block overrides an earlier one.
   always_ff @(posedge pck0 or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         extra       <= 1'b0;
         shift       <= '0;
         rx_shift    <= '0;
         hold        <= '0;
         full        <= 1'b0;
`ifdef SPI_TX_RETRY_EN
         loaded      <= 1'b0;
`endif
         miso_q      <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;

         if (accept) begin
            full <= 1'b1;
            hold <= bus.tx_data;
         end

         case (state)
            IDLE: begin
               miso_q <= 1'b0;
               if (ncs_fall) begin
                  state    <= SHIFT;
                  busy_q   <= 1'b1;
                  bit_cnt  <= '0;
                  extra    <= 1'b0;
                  rx_shift <= '0;
                  if (full) begin
                     shift  <= hold;
                     miso_q <= hold[WIDTH-1];
`ifdef SPI_TX_RETRY_EN
                     loaded <= 1'b1;
`else
                     full   <= 1'b0;
`endif
                  end else begin
                     // a word accepted in this same cycle stays held for the next frame
                     shift      <= IDLE_WORD;
                     miso_q     <= IDLE_WORD[WIDTH-1];
                     underrun_q <= 1'b1;
`ifdef SPI_TX_RETRY_EN
                     loaded     <= 1'b0;
`endif
                  end
               end
            end

            SHIFT: begin
               if (ncs_rise) begin
                  // abort: partial word dropped, nothing delivered
                  state       <= IDLE;
                  busy_q      <= 1'b0;
                  miso_q      <= 1'b0;
                  frame_err_q <= (bit_cnt != CNT_FULL) | extra;
               end else if (spck_rise) begin
                  rx_shift <= rx_next;
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == CNT_LAST) begin
                     rx_data_q  <= rx_next;
                     rx_valid_q <= 1'b1;
                     state      <= OVER;
                     miso_q     <= 1'b0;
                  end
               end else if (spck_fall && bit_cnt != '0) begin
                  shift  <= {shift[WIDTH-2:0], 1'b0};
                  miso_q <= shift[WIDTH-2];
               end
            end

            OVER: begin
               miso_q <= 1'b0;
               if (ncs_rise) begin
                  state       <= IDLE;
                  busy_q      <= 1'b0;
                  frame_err_q <= (bit_cnt != CNT_FULL) | extra;
`ifdef SPI_TX_RETRY_EN
                  if (bit_cnt == CNT_FULL && !extra && loaded) begin
                     full <= 1'b0;
                  end
                  loaded <= 1'b0;
`endif
               end else if (spck_rise) begin
                  // bit_cnt is already saturated at WIDTH; only remember the overrun
                  extra <= 1'b1;
               end
            end

            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               miso_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.miso      = miso_q;
   assign bus.tx_ready  = tx_ready;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.underrun  = underrun_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_miso_tx.sv
// tb_spi_miso_tx: directed frames against spi_miso_tx with hand-computed expectations.
// Build with +define+SPI_TX_RETRY_EN to exercise the retry variant.
module tb_spi_miso_tx;

   logic pck0 = 1'b0;
   logic rst;

   int errors = 0;
   int checks = 0;

   // pulse counters, sampled on the falling edge of pck0
   int n_rxv = 0;
   int n_und = 0;
   int n_ferr = 0;
   int rxv0, und0, ferr0;

   logic [15:0] got_word;
   logic        got_tail;

   spi_miso_tx_if #(.WIDTH(16)) bus ();

   spi_miso_tx #(
      .WIDTH       (16),
      .IDLE_WORD   (16'h0000),
      .SYNC_STAGES (2)
   ) dut (
      .pck0 (pck0),
      .rst  (rst),
      .bus  (bus.slave)
   );

   always #20 pck0 = ~pck0;

   // count output pulses away from the active edge
   always @(negedge pck0) begin
      if (bus.rx_valid)  n_rxv++;
      if (bus.underrun)  n_und++;
      if (bus.frame_err) n_ferr++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge pck0);
      #1;
   endtask

   task automatic snap();
      rxv0  = n_rxv;
      und0  = n_und;
      ferr0 = n_ferr;
   endtask

   task automatic push(input logic [15:0] w);
      bus.tx_data  = w;
      bus.tx_valid = 1'b1;
      cyc(1);
      bus.tx_valid = 1'b0;
   endtask

   // One SPI mode-0 frame of nbits clocks; bits beyond 16 drive mosi=1.
   // miso is sampled just before each spck rise, as the master would.
   task automatic do_frame(input logic [15:0] mosi_word, input int nbits,
                           input bit push_at_fall, input logic [15:0] push_word,
                           output logic [15:0] miso_word, output logic tail);
      miso_word = '0;
      tail      = 1'b0;
      bus.ncs   = 1'b0;
      if (push_at_fall) begin
         // ncs fall is acted on at the third pck0 edge after the pin changes
         cyc(2);
         bus.tx_data  = push_word;
         bus.tx_valid = 1'b1;
         cyc(1);
         bus.tx_valid = 1'b0;
         cyc(3);
      end else begin
         cyc(6);
      end
      for (int i = 0; i < nbits; i++) begin
         bus.mosi = (i < 16) ? mosi_word[15-i] : 1'b1;
         cyc(5);
         if (i < 16) miso_word[15-i] = bus.miso;
         else        tail = tail | bus.miso;
         bus.spck = 1'b1;
         cyc(5);
         bus.spck = 1'b0;
      end
      cyc(6);
      bus.ncs = 1'b1;
      cyc(6);
   endtask

   initial begin
      rst          = 1'b1;
      bus.spck     = 1'b0;
      bus.ncs      = 1'b1;
      bus.mosi     = 1'b0;
      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;
      cyc(3);
      rst = 1'b0;
      cyc(4);

      // reset state
      check("rst_miso",     32'(bus.miso),      32'd0);
      check("rst_tx_ready", 32'(bus.tx_ready),  32'd1);
      check("rst_rx_data",  32'(bus.rx_data),   32'h0);
      check("rst_busy",     32'(bus.busy),      32'd0);
      check("rst_pulses",   32'(n_rxv + n_und + n_ferr), 32'd0);

      // T1: held word goes out while a command comes in
      push(16'hA5C3);
      check("t1_tx_ready_full", 32'(bus.tx_ready), 32'd0);
      snap();
      do_frame(16'h1234, 16, 1'b0, 16'h0, got_word, got_tail);
      check("t1_miso",      32'(got_word),        32'hA5C3);
      check("t1_rx_data",   32'(bus.rx_data),     32'h1234);
      check("t1_rx_valid",  32'(n_rxv - rxv0),    32'd1);
      check("t1_underrun",  32'(n_und - und0),    32'd0);
      check("t1_frame_err", 32'(n_ferr - ferr0),  32'd0);
      check("t1_tx_ready",  32'(bus.tx_ready),    32'd1);
      check("t1_busy",      32'(bus.busy),        32'd0);

      // T2: nothing pending
      snap();
      do_frame(16'h0F0F, 16, 1'b0, 16'h0, got_word, got_tail);
      check("t2_miso",      32'(got_word),        32'h0000);
      check("t2_underrun",  32'(n_und - und0),    32'd1);
      check("t2_rx_valid",  32'(n_rxv - rxv0),    32'd1);
      check("t2_rx_data",   32'(bus.rx_data),     32'h0F0F);

      // T3: abort after 7 bits, then the next frame
      push(16'hBEEF);
      snap();
      do_frame(16'hFFFF, 7, 1'b0, 16'h0, got_word, got_tail);
      check("t3_frame_err", 32'(n_ferr - ferr0),  32'd1);
      check("t3_rx_valid",  32'(n_rxv - rxv0),    32'd0);
      check("t3_rx_data",   32'(bus.rx_data),     32'h0F0F);
      snap();
      do_frame(16'h1111, 16, 1'b0, 16'h0, got_word, got_tail);
`ifdef SPI_TX_RETRY_EN
      check("t3_resend",    32'(got_word),        32'hBEEF);
      check("t3_underrun",  32'(n_und - und0),    32'd0);
`else
      check("t3_resend",    32'(got_word),        32'h0000);
      check("t3_underrun",  32'(n_und - und0),    32'd1);
`endif
      check("t3_rx_data2",  32'(bus.rx_data),     32'h1111);

      // T4: 20 clocks in one frame
      push(16'hFFFF);
      snap();
      do_frame(16'h8001, 20, 1'b0, 16'h0, got_word, got_tail);
      check("t4_miso",      32'(got_word),        32'hFFFF);
      check("t4_miso_tail", 32'(got_tail),        32'd0);
      check("t4_rx_data",   32'(bus.rx_data),     32'h8001);
      check("t4_rx_valid",  32'(n_rxv - rxv0),    32'd1);
      check("t4_frame_err", 32'(n_ferr - ferr0),  32'd1);
`ifdef SPI_TX_RETRY_EN
      // an overrun frame is not clean, so the word is still held; drain it
      check("t4_held",      32'(bus.tx_ready),    32'd0);
      do_frame(16'h2222, 16, 1'b0, 16'h0, got_word, got_tail);
      check("t4_drain",     32'(got_word),        32'hFFFF);
`endif
      check("t4_tx_ready",  32'(bus.tx_ready),    32'd1);

      // T5: word offered in the same cycle the frame starts
      snap();
      do_frame(16'h3333, 16, 1'b1, 16'h5A5A, got_word, got_tail);
      check("t5_miso",      32'(got_word),        32'h0000);
      check("t5_underrun",  32'(n_und - und0),    32'd1);
      check("t5_held",      32'(bus.tx_ready),    32'd0);
      snap();
      do_frame(16'h4444, 16, 1'b0, 16'h0, got_word, got_tail);
      check("t5_next",      32'(got_word),        32'h5A5A);
      check("t5_underrun2", 32'(n_und - und0),    32'd0);
      check("t5_rx_data",   32'(bus.rx_data),     32'h4444);

      // T6: reset after 8 bits of a frame
      push(16'h1357);
      snap();
      bus.ncs = 1'b0;
      cyc(6);
      for (int i = 0; i < 8; i++) begin
         bus.mosi = 1'b1;
         cyc(5);
         bus.spck = 1'b1;
         cyc(5);
         bus.spck = 1'b0;
      end
      cyc(2);
      check("t6_busy_pre",  32'(bus.busy),        32'd1);
      rst = 1'b1;
      cyc(1);
      check("t6_miso",      32'(bus.miso),        32'd0);
      check("t6_tx_ready",  32'(bus.tx_ready),    32'd1);
      check("t6_rx_data",   32'(bus.rx_data),     32'h0);
      check("t6_busy",      32'(bus.busy),        32'd0);
      rst = 1'b0;
      cyc(2);
      bus.ncs = 1'b1;
      cyc(8);
      check("t6_no_pulses", 32'(n_rxv - rxv0 + n_und - und0 + n_ferr - ferr0), 32'd0);
      check("t6_idle",      32'(bus.busy),        32'd0);
      push(16'hC0DE);
      snap();
      do_frame(16'h4321, 16, 1'b0, 16'h0, got_word, got_tail);
      check("t6_miso_next", 32'(got_word),        32'hC0DE);
      check("t6_rx_next",   32'(bus.rx_data),     32'h4321);
      check("t6_rx_valid",  32'(n_rxv - rxv0),    32'd1);
      check("t6_frame_err", 32'(n_ferr - ferr0),  32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
